// File: rtl/npc_pkg.sv
// Shared types and constants for the npc core front end.
package npc_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} ifu_state_t;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
   localparam int          INST_W           = 32;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
endpackage

// File: rtl/ifu.sv
// Instruction fetch: one word in flight, REQ -> WAIT -> HOLD, redirects from execute.
// Optional IFU_EBREAK_HALT_EN: stop fetching for good after an ebreak is consumed.
module ifu
   import npc_pkg::*;
#(
   parameter int               XLEN     = 64,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [XLEN-1:0]   mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [INST_W-1:0] mem_resp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [XLEN-1:0]   inst_pc,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              halt
);

   ifu_state_t        r_state;
   logic [XLEN-1:0]   r_pc;
   logic              r_drop;
   logic              r_req_vld;
   logic              r_inst_vld;
   logic [INST_W-1:0] r_inst;
   logic [XLEN-1:0]   r_inst_pc;
   logic              w_halted;
   logic              w_is_ebreak;
   logic [XLEN-1:0]   w_redirect_pc;

   assign w_redirect_pc = redirect_pc & ~XLEN'(3);
   assign w_is_ebreak   = (mem_resp_data == INST_EBREAK);

`ifdef IFU_EBREAK_HALT_EN
   logic r_halt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_halt <= 1'b0;
      else if (r_state == WAIT && mem_resp_valid && !r_drop && !redirect_valid && w_is_ebreak)
         r_halt <= 1'b1;
   end

   assign w_halted = r_halt;
`else
   assign w_halted = 1'b0;
`endif

   // Outputs are registered alongside the state they belong to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_drop     <= 1'b0;
         r_req_vld  <= 1'b0;
         r_inst_vld <= 1'b0;
         r_inst     <= INST_NOP;
         r_inst_pc  <= '0;
      end else if (redirect_valid && !w_halted) begin
         r_pc <= w_redirect_pc;
         case (r_state)
            IDLE, HOLD: begin
               r_state    <= REQ;
               r_req_vld  <= 1'b1;
               r_inst_vld <= 1'b0;
            end
            REQ: begin
               if (mem_req_ready) begin
                  r_drop    <= 1'b1;
                  r_state   <= WAIT;
                  r_req_vld <= 1'b0;
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  r_drop    <= 1'b0;
                  r_state   <= REQ;
                  r_req_vld <= 1'b1;
               end else begin
                  r_drop <= 1'b1;
               end
            end
            default: ;
         endcase
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_halted) begin
                  r_state   <= REQ;
                  r_req_vld <= 1'b1;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  r_state   <= WAIT;
                  r_req_vld <= 1'b0;
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  if (r_drop) begin
                     r_drop    <= 1'b0;
                     r_state   <= REQ;
                     r_req_vld <= 1'b1;
                  end else begin
                     r_inst     <= mem_resp_data;
                     r_inst_pc  <= r_pc;
                     r_pc       <= r_pc + XLEN'(4);
                     r_state    <= HOLD;
                     r_inst_vld <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (inst_ready) begin
                  r_inst_vld <= 1'b0;
                  if (w_halted) begin
                     r_state <= IDLE;
                  end else begin
                     r_state   <= REQ;
                     r_req_vld <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req_valid = r_req_vld;
   assign mem_req_addr  = r_pc;
   assign inst_valid    = r_inst_vld;
   assign inst          = r_inst;
   assign inst_pc       = r_inst_pc;
   assign halt          = w_halted;

   logic w_unused;
   assign w_unused = w_is_ebreak;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset, 0-wait fetch, backpressure, stalls, redirects, async reset, ebreak.
module tb_ifu;
   import npc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        halt;

   int checks = 0;
   int errors = 0;

   ifu dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starting in REQ at pc: accept, answer with data, consume; ends in REQ at pc+4.
   task automatic fetch(input logic [31:0] data, input logic [63:0] pc);
      chk("f_req_vld", 64'(mem_req_valid), 64'd1);
      chk("f_req_addr", mem_req_addr, pc);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("f_wait_req", 64'(mem_req_valid), 64'd0);
      chk("f_wait_ivld", 64'(inst_valid), 64'd0);
      mem_resp_valid = 1'b1;
      mem_resp_data  = data;
      step();
      mem_resp_valid = 1'b0;
      chk("f_ivld", 64'(inst_valid), 64'd1);
      chk("f_inst", 64'(inst), 64'(data));
      chk("f_inst_pc", inst_pc, pc);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("f_ivld_drop", 64'(inst_valid), 64'd0);
   endtask

   initial begin
      rst = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      #12;
      chk("rst_req_vld", 64'(mem_req_valid), 64'd0);
      chk("rst_ivld", 64'(inst_valid), 64'd0);
      chk("rst_inst", 64'(inst), 64'h13);
      chk("rst_inst_pc", inst_pc, 64'd0);
      chk("rst_halt", 64'(halt), 64'd0);
      step();
      rst = 1'b1;
      chk("idle_req_vld", 64'(mem_req_valid), 64'd0);
      step();

      // 0-wait memory: one instruction every 3 cycles
      fetch(32'h1111_0001, 64'h8000_0000);
      fetch(32'h1111_0002, 64'h8000_0004);
      fetch(32'h1111_0003, 64'h8000_0008);

      // decode backpressure in HOLD
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h2222_0004;
      step();
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_ivld", 64'(inst_valid), 64'd1);
         chk("bp_inst", 64'(inst), 64'h2222_0004);
         chk("bp_inst_pc", inst_pc, 64'h8000_000C);
         chk("bp_req_vld", 64'(mem_req_valid), 64'd0);
         step();
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("bp_next_addr", mem_req_addr, 64'h8000_0010);
      chk("bp_next_vld", 64'(mem_req_valid), 64'd1);

      // memory stall: request held, response late
      for (int i = 0; i < 4; i++) begin
         chk("st_req_vld", 64'(mem_req_valid), 64'd1);
         chk("st_req_addr", mem_req_addr, 64'h8000_0010);
         step();
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("st_wait_ivld", 64'(inst_valid), 64'd0);
         chk("st_wait_req", 64'(mem_req_valid), 64'd0);
         step();
      end
      mem_resp_valid = 1'b1; mem_resp_data = 32'h3333_0010;
      step();
      mem_resp_valid = 1'b0;
      chk("st_inst", 64'(inst), 64'h3333_0010);
      chk("st_inst_pc", inst_pc, 64'h8000_0010);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("st_next_addr", mem_req_addr, 64'h8000_0014);

      // redirect while waiting: stale response dropped
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
      step();
      redirect_valid = 1'b0;
      chk("rw_wait_req", 64'(mem_req_valid), 64'd0);
      mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
      step();
      mem_resp_valid = 1'b0;
      chk("rw_drop_ivld", 64'(inst_valid), 64'd0);
      chk("rw_inst_kept", 64'(inst), 64'h3333_0010);
      fetch(32'h4444_0100, 64'h8000_0100);

      // redirect in HOLD with decode ready: held word discarded
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_0104;
      step();
      mem_resp_valid = 1'b0;
      chk("rh_inst_pc", inst_pc, 64'h8000_0104);
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0203;
      step();
      inst_ready = 1'b0; redirect_valid = 1'b0;
      chk("rh_ivld", 64'(inst_valid), 64'd0);
      fetch(32'h6666_0200, 64'h8000_0200);

      // async reset mid-WAIT with late response
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      rst = 1'b0;
      #1;
      chk("ar_req_vld", 64'(mem_req_valid), 64'd0);
      chk("ar_inst", 64'(inst), 64'h13);
      chk("ar_inst_pc", inst_pc, 64'd0);
      chk("ar_addr", mem_req_addr, 64'h8000_0000);
      mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0;
      step();
      chk("ar_hold_ivld", 64'(inst_valid), 64'd0);
      rst = 1'b1;
      step();
      mem_resp_valid = 1'b0;
      chk("ar_ivld", 64'(inst_valid), 64'd0);
      chk("ar_inst_ign", 64'(inst), 64'h13);
      fetch(32'h7777_0000, 64'h8000_0000);

      // ebreak word
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0010_0073;
      step();
      mem_resp_valid = 1'b0;
      chk("eb_inst", 64'(inst), 64'h0010_0073);
      inst_ready = 1'b1;
`ifdef IFU_EBREAK_HALT_EN
      chk("eb_halt", 64'(halt), 64'd1);
      step();
      inst_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("eb_no_req", 64'(mem_req_valid), 64'd0);
         chk("eb_halt_kept", 64'(halt), 64'd1);
      end
      redirect_valid = 1'b0;
`else
      chk("eb_halt", 64'(halt), 64'd0);
      step();
      inst_ready = 1'b0;
      chk("eb_next_vld", 64'(mem_req_valid), 64'd1);
      chk("eb_next_addr", mem_req_addr, 64'h8000_0008);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
Instruction fetch unit for the npc RV64 core; sits directly upstream of the decode stage and supplies the 32-bit instruction word consumed by idu.
- Owns the architectural fetch PC.
- Issues word fetches to instruction memory over a valid/ready request and response-valid interface.
- Presents one instruction at a time to decode with a valid/ready handshake.
- Accepts redirects (jump/branch/trap) from execute.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, fetch address after reset
XLEN, 64, PC/address width

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
mem_req_valid  output  1  fetch request pending
mem_req_ready  input  1  memory accepts request this cycle
mem_req_addr  output  XLEN  word-aligned fetch address
mem_resp_valid  input  1  instruction data valid this cycle
mem_resp_data  input  32  fetched instruction word
inst_valid  output  1  inst/inst_pc valid to decode
inst_ready  input  1  decode consumes instruction this cycle
inst  output  32  instruction word to idu
inst_pc  output  XLEN  PC of inst
redirect_valid  input  1  execute requests PC change
redirect_pc  input  XLEN  new fetch PC
halt  output  1  fetch stopped on ebreak (optional feature; else tied 0)

Behaviour:
Reset values (async, rst=0):
- pc_q=RESET_PC; state=IDLE; drop_q=0.
- mem_req_valid=0, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=0, halt=0.
- Reset mid-operation abandons any outstanding fetch; a late mem_resp_valid arriving in IDLE is ignored.

States IDLE, REQ, WAIT, HOLD. Outputs:
- mem_req_valid=1 only in REQ, with mem_req_addr=pc_q.
- inst_valid=1 only in HOLD.

Transitions without redirect:
- IDLE -> REQ unconditionally on the first clock after reset release.
- REQ: if mem_req_ready, go to WAIT; else stay in REQ with the address held stable.
- WAIT: if mem_resp_valid and drop_q=1, clear drop_q and go to REQ (new pc_q).
- WAIT: if mem_resp_valid and drop_q=0, capture inst<=mem_resp_data and inst_pc<=pc_q, set pc_q<=pc_q+4 (wraps modulo 2^XLEN), go to HOLD.
- WAIT: with no response, stay in WAIT for any number of cycles.
- HOLD: if inst_ready, go to REQ; inst_valid drops next cycle. inst and inst_pc stay stable while inst_valid=1 and inst_ready=0.

Throughput and latency:
- One instruction in flight at a time.
- Minimum 3 cycles from REQ to inst_valid with 0-wait memory: REQ accepted, response in WAIT, HOLD.

Redirect (highest priority, any state):
- pc_q<=redirect_pc with bits [1:0] forced to 0.
- IDLE or HOLD: go to REQ. Any instruction in HOLD is discarded, even if inst_ready is also high that cycle.
- REQ without mem_req_ready: stay in REQ; the address changes next cycle (memory tolerates retraction on redirect only).
- REQ with mem_req_ready: the old-address request is already issued. Set drop_q=1 and go to WAIT.
- WAIT without response: set drop_q=1 and stay in WAIT.
- WAIT with response this cycle: discard the response, drop_q=0, go to REQ.

Other rules:
- A repeated redirect while drop_q=1 only updates pc_q.
- mem_resp_valid outside WAIT is ignored.

Optional Feature:
Macro: IFU_EBREAK_HALT_EN
- Defined:
  - When an instruction equal to 32'h0010_0073 is captured into HOLD, set halt_q=1.
  - After decode consumes it, the FSM enters IDLE and stays there. No further requests; redirects are ignored.
  - halt=1 until reset.
- Undefined: halt tied 0; ebreak is fetched like any other word.

Decomposition:
- Package npc_pkg holds:
  - ifu_state_t enum {IDLE, REQ, WAIT, HOLD}
  - RESET_PC_DEFAULT
  - INST_NOP = 32'h0000_0013
  - INST_EBREAK = 32'h0010_0073
  - INST_W = 32
- No sub-module. PC register, incrementer and FSM stay inline in ifu.

Test Plan:
1. Reset release with 0-wait memory (req_ready=1, resp one cycle later, inst_ready=1) -> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008; inst_pc matches each; one instruction every 3 cycles.
2. Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc stable, no mem_req_valid; then ready=1 -> next REQ at pc+4.
3. Memory stall: mem_req_ready low 4 cycles, then resp delayed 3 cycles -> address held stable in REQ; single capture; pc increments exactly once.
4. Redirect in WAIT to 0x8000_0100 -> the old response is dropped and never shown to decode; next request is 0x8000_0100, delivered with inst_pc=0x8000_0100.
5. Redirect in HOLD together with inst_ready=1, redirect_pc=0x8000_0203 -> held instruction discarded; next address 0x8000_0200.
6. Async reset asserted mid-WAIT, late mem_resp_valid during/after reset -> outputs at reset values, response ignored, fetch restarts at RESET_PC. With IFU_EBREAK_HALT_EN, fetched 0x0010_0073 -> halt=1 and no further mem_req_valid.
